// File: rtl/ft245_uart_bridge.sv
// ft245_uart_bridge
//   Responder side of an FT245-style asynchronous FIFO interface, backed by an
//   8N1 UART and two small FIFOs. Serial bytes land in the RX FIFO and are read
//   by the mux via fifo_rd; mux writes via fifo_wr go into the TX FIFO and are
//   shifted out serially. Strobes share clk with the mux (no resynchronising).
//
//   Parameters:
//     CLK_DIV     clk cycles per UART bit (>= 4)
//     DEPTH_LOG2  log2 of each FIFO depth
//   Ports:
//     clk         system clock
//     reset       synchronous, active-low
//     fifo_rxf    low = RX FIFO non-empty (registered)
//     fifo_txe    high = TX FIFO full (registered)
//     fifo_rd     active-low read strobe; drives fifo_data while low
//     fifo_wr     active-low write strobe; captured on its falling edge
//     fifo_data   shared 7-bit data bus
//     uart_rxd    asynchronous serial input, idle high
//     uart_txd    serial output, idle high
//     rx_overrun  sticky: a received byte was dropped on a full RX FIFO
module ft245_uart_bridge #(
    parameter int CLK_DIV    = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       fifo_rxf,
    output logic       fifo_txe,
    input  logic       fifo_rd,
    input  logic       fifo_wr,
    inout  logic [6:0] fifo_data,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       rx_overrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int BW    = $clog2(CLK_DIV);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic [6:0]            rx_mem [DEPTH];
    logic [6:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;
    logic [CW-1:0]         rx_count, tx_count;
    logic                  rd_q, wr_q;

    logic                  rx_s1, rx_s2;
    uart_state_t           rx_state, tx_state;
    logic [BW-1:0]         rx_baud, tx_baud;
    logic [2:0]            rx_bit, tx_bit;
    logic [7:0]            rx_shift, tx_shift;

    logic rx_done, rx_full, rx_push, rx_pop;
    logic tx_push, tx_pop;

    // Bus is driven straight from fifo_rd so data is valid within the strobe clk.
    assign fifo_data = fifo_rd ? 'z : rx_mem[rx_rptr];

    assign rx_pop  = !rd_q && fifo_rd && (rx_count != '0);
    assign rx_done = (rx_state == STOP) && (rx_baud == BAUD_LAST) && rx_s2;
    assign rx_full = (rx_count == FULL);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign rx_push = rx_done && (!rx_full || rx_pop);

    // TX pops either from IDLE or directly at the end of a stop bit so that
    // queued bytes go out with no idle gap between frames.
    assign tx_pop  = (tx_count != '0) &&
                     ((tx_state == IDLE) || ((tx_state == STOP) && (tx_baud == BAUD_LAST)));
    assign tx_push = wr_q && !fifo_wr && ((tx_count != FULL) || tx_pop);

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= rx_shift[6:0];
        if (tx_push) tx_mem[tx_wptr] <= fifo_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_wptr    <= '0;
            rx_rptr    <= '0;
            tx_wptr    <= '0;
            tx_rptr    <= '0;
            rx_count   <= '0;
            tx_count   <= '0;
            rd_q       <= 1'b1;
            wr_q       <= 1'b1;
            fifo_rxf   <= 1'b1;
            fifo_txe   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rd_q     <= fifo_rd;
            wr_q     <= fifo_wr;
            fifo_rxf <= (rx_count == '0);
            fifo_txe <= (tx_count == FULL);
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            if (rx_done && rx_full && !rx_pop) rx_overrun <= 1'b1;
        end
    end

    // Receiver: start bit is re-checked at mid-bit, data sampled at mid-bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= uart_rxd;
            rx_s2 <= rx_s1;
            case (rx_state)
                IDLE: begin
                    rx_baud <= '0;
                    if (!rx_s2) rx_state <= START;
                end
                START: begin
                    if (rx_baud == BAUD_HALF) begin
                        rx_baud  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? IDLE : DATA;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud  <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= STOP;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud  <= '0;
                        rx_state <= IDLE;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // Transmitter: bit 7 of the shift register is forced to 0 on load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state <= IDLE;
            uart_txd <= 1'b1;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                IDLE: begin
                    tx_baud <= '0;
                    if (tx_pop) begin
                        tx_shift <= {1'b0, tx_mem[tx_rptr]};
                        uart_txd <= 1'b0;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud  <= '0;
                        tx_bit   <= '0;
                        uart_txd <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_state <= DATA;
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud <= '0;
                        if (tx_bit == 3'd7) begin
                            uart_txd <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            uart_txd <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud <= '0;
                        if (tx_pop) begin
                            tx_shift <= {1'b0, tx_mem[tx_rptr]};
                            uart_txd <= 1'b0;
                            tx_state <= START;
                        end else begin
                            tx_state <= IDLE;
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

endmodule
